sync_down_cntr: RTL and testbench

SYNC_DOWN_CNTR -- requirements
Module: sync_down_cntr

---
 rtl/sync_cntr_pkg.sv | 10 +
 rtl/tff_stage.sv | 20 ++
 rtl/sync_down_cntr.sv | 105 ++++++++++
 tb/tb_sync_down_cntr.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/sync_cntr_pkg.sv
// Shared definitions for the synchronous down counter: FSM state encoding.
package sync_cntr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } cntr_state_e;

endpackage

// File: rtl/tff_stage.sv
// Single T flip-flop bit of the counter with synchronous active-high clear.
module tff_stage (
  input  logic clk,
  input  logic clr,
  input  logic t,
  output logic q
);

  // Toggle-on-t storage bit; clear wins over toggle.
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/sync_down_cntr.sv
// Loadable down counter with one-shot / periodic modes, built from T flip-flop stages.
module sync_down_cntr #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy
);

  import sync_cntr_pkg::*;

  cntr_state_e      state_r;
  cntr_state_e      state_nxt_s;
  logic [WIDTH-1:0] rl_q_r;
  logic [WIDTH-1:0] rl_q_nxt_s;
  logic [WIDTH-1:0] next_q_s;
  logic [WIDTH-1:0] t_s;
  logic             tc_nxt_s;
  logic             wr_s;
  logic             en_dec_s;

  // Next-state, next-count and terminal-count decode.
  always_comb begin
    state_nxt_s = state_r;
    rl_q_nxt_s  = rl_q_r;
    next_q_s    = q;
    tc_nxt_s    = 1'b0;
    wr_s        = 1'b0;
    en_dec_s    = 1'b0;
    if (load) begin
      next_q_s    = load_val;
      rl_q_nxt_s  = load_val;
      wr_s        = 1'b1;
      state_nxt_s = (load_val != {WIDTH{1'b0}}) ? RUN : IDLE;
    end else begin
      case (state_r)
        RUN: begin
          if (en) begin
            if (q != {WIDTH{1'b0}}) begin
              en_dec_s = 1'b1;
              next_q_s = q - {{(WIDTH-1){1'b0}}, 1'b1};
              tc_nxt_s = (q == {{(WIDTH-1){1'b0}}, 1'b1});
            end else if (auto_reload) begin
              next_q_s = rl_q_r;
              wr_s     = 1'b1;
            end else begin
              state_nxt_s = DONE;
            end
          end else begin
            state_nxt_s = RUN;
          end
        end
        IDLE:    state_nxt_s = IDLE;
        DONE:    state_nxt_s = DONE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Stage toggles: parallel write flips differing bits, decrement is a borrow ripple.
  always_comb begin
    logic zeros_v;
    zeros_v = 1'b1;
    t_s     = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (wr_s) begin
        t_s[i] = q[i] ^ next_q_s[i];
      end else begin
        t_s[i] = en_dec_s & zeros_v;
      end
      zeros_v = zeros_v & ~q[i];
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
    tff_stage u_stage (
      .clk (clk),
      .clr (clr),
      .t   (t_s[gi]),
      .q   (q[gi])
    );
  end

  // Control registers: FSM state, reload value and terminal-count pulse.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r <= IDLE;
      rl_q_r  <= {WIDTH{1'b0}};
      tc      <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      rl_q_r  <= rl_q_nxt_s;
      tc      <= tc_nxt_s;
    end
  end

  assign busy = (state_r == RUN);

endmodule

// File: tb/tb_sync_down_cntr.sv
// Directed, table-driven bench for sync_down_cntr at WIDTH=3 (default) and WIDTH=4.
module tb_sync_down_cntr;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [3:0] lv = 4'd0;
  logic       en = 1'b0;
  logic       ar = 1'b0;
  logic [2:0] q3;
  logic       tc3, busy3;
  logic [3:0] q4;
  logic       tc4, busy4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sync_down_cntr u3 (
    .clk(clk), .clr(clr), .load(load), .load_val(lv[2:0]), .en(en),
    .auto_reload(ar), .q(q3), .tc(tc3), .busy(busy3)
  );

  sync_down_cntr #(.WIDTH(4)) u4 (
    .clk(clk), .clr(clr), .load(load), .load_val(lv), .en(en),
    .auto_reload(ar), .q(q4), .tc(tc4), .busy(busy4)
  );

  typedef struct {
    string      tag;
    logic       clr;
    logic       load;
    logic [3:0] lv;
    logic       en;
    logic       ar;
    logic [3:0] q;
    logic       tc;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string tag, input logic c, input logic ld,
                              input logic [3:0] v, input logic e, input logic a,
                              input logic [3:0] eq, input logic etc, input logic eb);
    vec_t r;
    r.tag = tag; r.clr = c; r.load = ld; r.lv = v; r.en = e; r.ar = a;
    r.q = eq; r.tc = etc; r.busy = eb;
    vecs.push_back(r);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // tag, clr, load, lv, en, ar -> q, tc, busy
    add("reset",    1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    add("os_load",  1'b0, 1'b1, 4'd5, 1'b1, 1'b0, 4'd5, 1'b0, 1'b1);
    add("os_4",     1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd4, 1'b0, 1'b1);
    add("os_3",     1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b1);
    add("os_2",     1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1);
    add("os_1",     1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1);
    add("os_0tc",   1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
    add("os_done",  1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    add("os_hold",  1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    add("per_load", 1'b0, 1'b1, 4'd2, 1'b1, 1'b1, 4'd2, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      add("per_1",  1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b1);
      add("per_0",  1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1);
      add("per_2",  1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd2, 1'b0, 1'b1);
    end
    add("per_1b",   1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b1);
    add("per_0b",   1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1);
    add("eg_load",  1'b0, 1'b1, 4'd4, 1'b1, 1'b0, 4'd4, 1'b0, 1'b1);
    add("eg_en1",   1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b1);
    add("eg_en0a",  1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1);
    add("eg_en0b",  1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1);
    add("eg_en1b",  1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1);
    add("rm_load",  1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 4'd7, 1'b0, 1'b1);
    add("rm_6",     1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd6, 1'b0, 1'b1);
    add("rm_5",     1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b0, 1'b1);
    add("rm_4",     1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd4, 1'b0, 1'b1);
    add("rm_clr",   1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    add("rm_after", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    add("clr_vs_ld",1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    add("sl_load",  1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1);
    add("sl_1",     1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1);
    add("sl_ld6",   1'b0, 1'b1, 4'd6, 1'b1, 1'b0, 4'd6, 1'b0, 1'b1);
    add("sl_ld0",   1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    add("sl_idle",  1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    add("ar_load",  1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1);
    add("ar_1",     1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1);
    add("ar_0",     1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1);
    add("ar_done",  1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    add("hz_load",  1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1);
    add("hz_0",     1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1);
    add("hz_hold",  1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
    add("hz_rel",   1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      clr = vecs[i].clr; load = vecs[i].load; lv = vecs[i].lv;
      en = vecs[i].en;   ar = vecs[i].ar;
      step();
      chk({vecs[i].tag, ".q3"},    int'(q3),    int'(vecs[i].q));
      chk({vecs[i].tag, ".tc3"},   int'(tc3),   int'(vecs[i].tc));
      chk({vecs[i].tag, ".busy3"}, int'(busy3), int'(vecs[i].busy));
      chk({vecs[i].tag, ".q4"},    int'(q4),    int'(vecs[i].q));
      chk({vecs[i].tag, ".tc4"},   int'(tc4),   int'(vecs[i].tc));
      chk({vecs[i].tag, ".busy4"}, int'(busy4), int'(vecs[i].busy));
    end

    // Outputs must not move between edges.
    load = 1'b1; lv = 4'd6; en = 1'b0; ar = 1'b0; clr = 1'b0;
    step();
    load = 1'b0; en = 1'b1;
    #3;
    chk("stable_mid.q3", int'(q3), 6);
    chk("stable_mid.q4", int'(q4), 6);
    step();
    chk("stable_after.q3", int'(q3), 5);

    // WIDTH=4 one-shot from all-ones: 15..0 then hold, never wrapping.
    clr = 1'b1; load = 1'b0; en = 1'b0;
    step();
    clr = 1'b0; load = 1'b1; lv = 4'd15; en = 1'b1; ar = 1'b0;
    step();
    chk("w4_load.q", int'(q4), 15);
    load = 1'b0; lv = 4'd0;
    for (int k = 14; k >= 0; k--) begin
      step();
      chk($sformatf("w4_cnt%0d.q", k), int'(q4), k);
      chk($sformatf("w4_cnt%0d.tc", k), int'(tc4), (k == 0) ? 1 : 0);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("w4_post%0d.q", k), int'(q4), 0);
      chk($sformatf("w4_post%0d.busy", k), int'(busy4), 0);
      chk($sformatf("w4_post%0d.tc", k), int'(tc4), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
